// File: rtl/trap_ctrl_pkg.sv
// Shared constants and state encoding for the machine-mode trap sequencer.
// CSR addresses, cause codes and mstatus bit positions follow the privileged spec.
package trap_ctrl_pkg;

   localparam int unsigned INSTR_WIDTH = 32;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int unsigned CAUSE_ILLEGAL_INSTR = 2;
   localparam int unsigned CAUSE_BREAKPOINT    = 3;
   localparam int unsigned CAUSE_ECALL_M       = 11;
   localparam int unsigned IRQ_M_EXT           = 11;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_EPC    = 3'd1,
      W_CAUSE  = 3'd2,
      W_TVAL   = 3'd3,
      W_STATUS = 3'd4,
      REDIR    = 3'd5
   } state_t;

endpackage

// File: rtl/trap_ctrl_cause_enc.sv
// Combinational priority encoder: picks the winning trap/mret event and derives
// its cause, tval and redirect target from the current CSR values.
module trap_cause_enc
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic                   instr_valid_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic                   id_ilegl_instr_i,
   input  logic                   id_ebreak_i,
   input  logic                   id_ecall_i,
   input  logic                   id_mret_i,
   input  logic                   irq_i,
   input  logic                   mie_i,
   input  logic [XLEN-1:0]        mtvec_i,
   input  logic [XLEN-1:0]        mepc_i,
   output logic                   evt_o,
   output logic                   is_irq_o,
   output logic                   is_mret_o,
   output logic [XLEN-1:0]        cause_o,
   output logic [XLEN-1:0]        tval_o,
   output logic [XLEN-1:0]        target_o
);

   logic [XLEN-1:0] base;

   always_comb begin
      base      = mtvec_i & ~XLEN'(3);
      evt_o     = 1'b0;
      is_irq_o  = 1'b0;
      is_mret_o = 1'b0;
      cause_o   = '0;
      tval_o    = '0;
      target_o  = base;
      if (instr_valid_i) begin
         if (irq_i && mie_i) begin
            evt_o    = 1'b1;
            is_irq_o = 1'b1;
            cause_o  = {1'b1, (XLEN-1)'(IRQ_M_EXT)};
            // vectored mode only offsets interrupts, never exceptions
            if (mtvec_i[1:0] == 2'b01)
               target_o = base + XLEN'(IRQ_M_EXT << 2);
         end else if (id_ilegl_instr_i) begin
            evt_o   = 1'b1;
            cause_o = XLEN'(CAUSE_ILLEGAL_INSTR);
            tval_o  = XLEN'(instr_i);
         end else if (id_ebreak_i) begin
            evt_o   = 1'b1;
            cause_o = XLEN'(CAUSE_BREAKPOINT);
            tval_o  = pc_i;
         end else if (id_ecall_i) begin
            evt_o   = 1'b1;
            cause_o = XLEN'(CAUSE_ECALL_M);
         end else if (id_mret_i) begin
            evt_o     = 1'b1;
            is_mret_o = 1'b1;
            target_o  = mepc_i & ~XLEN'(3);
         end
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: serialises mepc/mcause/mtval/mstatus updates over
// the single CSR write port, then redirects fetch; also executes mret.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   instr_valid_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic                   id_ilegl_instr_i,
   input  logic                   id_ebreak_i,
   input  logic                   id_ecall_i,
   input  logic                   id_mret_i,
   input  logic                   irq_i,
   input  logic [XLEN-1:0]        csr_mstatus_i,
   input  logic [XLEN-1:0]        csr_mtvec_i,
   input  logic [XLEN-1:0]        csr_mepc_i,
   output logic                   stall_o,
   output logic                   flush_o,
   output logic                   csr_we_o,
   output logic [11:0]            csr_waddr_o,
   output logic [XLEN-1:0]        csr_wdata_o,
   output logic                   redirect_o,
   output logic [XLEN-1:0]        redirect_pc_o,
   output logic                   irq_ack_o
);

   state_t          state_q;
   logic [XLEN-1:0] epc_q, cause_q, tval_q, mstatus_q, target_q;
   logic            irq_q;

   logic            evt, is_irq, is_mret, detect;
   logic [XLEN-1:0] cause, tval, target, trap_ms, mret_ms;

   trap_cause_enc #(.XLEN(XLEN)) u_enc (
      .instr_valid_i    (instr_valid_i),
      .instr_i          (instr_i),
      .pc_i             (pc_i),
      .id_ilegl_instr_i (id_ilegl_instr_i),
      .id_ebreak_i      (id_ebreak_i),
      .id_ecall_i       (id_ecall_i),
      .id_mret_i        (id_mret_i),
      .irq_i            (irq_i),
      .mie_i            (csr_mstatus_i[MSTATUS_MIE]),
      .mtvec_i          (csr_mtvec_i),
      .mepc_i           (csr_mepc_i),
      .evt_o            (evt),
      .is_irq_o         (is_irq),
      .is_mret_o        (is_mret),
      .cause_o          (cause),
      .tval_o           (tval),
      .target_o         (target)
   );

   always_comb begin
      trap_ms = csr_mstatus_i;
      trap_ms[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
      trap_ms[MSTATUS_MIE]  = 1'b0;
      trap_ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mret_ms = csr_mstatus_i;
      mret_ms[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
      mret_ms[MSTATUS_MPIE] = 1'b1;
      mret_ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   // rst_n gates detection so every output reads 0 while reset is held
   assign detect = rst_n && (state_q == IDLE) && evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         epc_q     <= '0;
         cause_q   <= '0;
         tval_q    <= '0;
         mstatus_q <= '0;
         target_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (detect) begin
               epc_q     <= pc_i;
               cause_q   <= cause;
               tval_q    <= tval;
               mstatus_q <= is_mret ? mret_ms : trap_ms;
               target_q  <= target;
               irq_q     <= is_irq;
               state_q   <= is_mret ? W_STATUS : W_EPC;
            end
            W_EPC:    state_q <= W_CAUSE;
            W_CAUSE:  state_q <= W_TVAL;
            W_TVAL:   state_q <= W_STATUS;
            W_STATUS: state_q <= REDIR;
            REDIR:    state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      stall_o       = detect || (state_q != IDLE);
      flush_o       = detect;
      csr_we_o      = 1'b0;
      csr_waddr_o   = '0;
      csr_wdata_o   = '0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      irq_ack_o     = 1'b0;
      case (state_q)
         W_EPC:    begin csr_we_o = 1'b1; csr_waddr_o = CSR_MEPC;    csr_wdata_o = epc_q;     end
         W_CAUSE:  begin csr_we_o = 1'b1; csr_waddr_o = CSR_MCAUSE;  csr_wdata_o = cause_q;   end
         W_TVAL:   begin csr_we_o = 1'b1; csr_waddr_o = CSR_MTVAL;   csr_wdata_o = tval_q;    end
         W_STATUS: begin csr_we_o = 1'b1; csr_waddr_o = CSR_MSTATUS; csr_wdata_o = mstatus_q; end
         REDIR:    begin redirect_o = 1'b1; redirect_pc_o = target_q; irq_ack_o = irq_q;      end
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: hand-computed CSR write sequences, redirects
// and stall windows for traps, interrupts, mret and mid-sequence reset.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid_i;
   logic [31:0] instr_i;
   logic [63:0] pc_i;
   logic        id_ilegl_instr_i, id_ebreak_i, id_ecall_i, id_mret_i, irq_i;
   logic [63:0] csr_mstatus_i, csr_mtvec_i, csr_mepc_i;
   logic        stall_o, flush_o, csr_we_o, redirect_o, irq_ack_o;
   logic [11:0] csr_waddr_o;
   logic [63:0] csr_wdata_o, redirect_pc_o;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   trap_ctrl #(.XLEN(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .instr_valid_i    (instr_valid_i),
      .instr_i          (instr_i),
      .pc_i             (pc_i),
      .id_ilegl_instr_i (id_ilegl_instr_i),
      .id_ebreak_i      (id_ebreak_i),
      .id_ecall_i       (id_ecall_i),
      .id_mret_i        (id_mret_i),
      .irq_i            (irq_i),
      .csr_mstatus_i    (csr_mstatus_i),
      .csr_mtvec_i      (csr_mtvec_i),
      .csr_mepc_i       (csr_mepc_i),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .csr_we_o         (csr_we_o),
      .csr_waddr_o      (csr_waddr_o),
      .csr_wdata_o      (csr_wdata_o),
      .redirect_o       (redirect_o),
      .redirect_pc_o    (redirect_pc_o),
      .irq_ack_o        (irq_ack_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic st, input logic fl, input logic we,
                             input logic [11:0] ad, input logic [63:0] wd, input logic rd,
                             input logic [63:0] rp, input logic ak);
      chk({tag, " stall"},  64'(stall_o),     64'(st));
      chk({tag, " flush"},  64'(flush_o),     64'(fl));
      chk({tag, " we"},     64'(csr_we_o),    64'(we));
      chk({tag, " waddr"},  64'(csr_waddr_o), 64'(ad));
      chk({tag, " wdata"},  csr_wdata_o,      wd);
      chk({tag, " redir"},  64'(redirect_o),  64'(rd));
      chk({tag, " rpc"},    redirect_pc_o,    rp);
      chk({tag, " ack"},    64'(irq_ack_o),   64'(ak));
   endtask

   task automatic cyc(input string tag, input logic st, input logic fl, input logic we,
                      input logic [11:0] ad, input logic [63:0] wd, input logic rd,
                      input logic [63:0] rp, input logic ak);
      @(negedge clk);
      check_outs(tag, st, fl, we, ad, wd, rd, rp, ak);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      instr_valid_i = 1'b0; instr_i = '0; pc_i = '0;
      id_ilegl_instr_i = 1'b0; id_ebreak_i = 1'b0; id_ecall_i = 1'b0; id_mret_i = 1'b0;
      irq_i = 1'b0; csr_mstatus_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0;
   endtask

   // Inputs stay asserted through the sequence to show they are ignored outside IDLE.
   task automatic run_trap(input string tag, input logic [63:0] epc, input logic [63:0] cause,
                           input logic [63:0] tval, input logic [63:0] ms,
                           input logic [63:0] tgt, input logic ack);
      cyc({tag, " T"},   1, 1, 0, 12'h000, 64'h0, 0, 64'h0, 0);
      adv();
      cyc({tag, " T+1"}, 1, 0, 1, 12'h341, epc,   0, 64'h0, 0);
      adv();
      cyc({tag, " T+2"}, 1, 0, 1, 12'h342, cause, 0, 64'h0, 0);
      adv();
      cyc({tag, " T+3"}, 1, 0, 1, 12'h343, tval,  0, 64'h0, 0);
      adv();
      cyc({tag, " T+4"}, 1, 0, 1, 12'h300, ms,    0, 64'h0, 0);
      adv();
      cyc({tag, " T+5"}, 1, 0, 0, 12'h000, 64'h0, 1, tgt,   ack);
      adv();
      clear_inputs();
      cyc({tag, " T+6"}, 0, 0, 0, 12'h000, 64'h0, 0, 64'h0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      #3;
      check_outs("reset", 0, 0, 0, 12'h000, 64'h0, 0, 64'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      adv();

      // illegal instruction, direct mtvec, MIE=1 without irq
      instr_valid_i = 1; id_ilegl_instr_i = 1; instr_i = 32'hFFFF_FFFF;
      pc_i = 64'h8000_0100; csr_mtvec_i = 64'h8000_0000; csr_mstatus_i = 64'h8;
      run_trap("illegal", 64'h8000_0100, 64'd2, 64'hFFFF_FFFF, 64'h1880, 64'h8000_0000, 0);
      adv();

      // ecall with vectored mtvec: exceptions still go to base
      instr_valid_i = 1; id_ecall_i = 1; pc_i = 64'h200; csr_mtvec_i = 64'h1001; csr_mstatus_i = 64'h0;
      run_trap("ecall", 64'h200, 64'd11, 64'h0, 64'h1800, 64'h1000, 0);
      adv();

      // irq without a valid instruction is not taken
      irq_i = 1; csr_mstatus_i = 64'h8; csr_mtvec_i = 64'h1001;
      cyc("irq_novalid", 0, 0, 0, 12'h000, 64'h0, 0, 64'h0, 0);
      adv();
      // irq with a concurrent ecall: irq wins, vectored offset applies
      instr_valid_i = 1; id_ecall_i = 1; pc_i = 64'h300;
      run_trap("irq", 64'h300, 64'h8000_0000_0000_000B, 64'h0, 64'h1880, 64'h102C, 1);
      adv();

      // mret: MPIE=1, MIE=0, mepc low bits masked
      instr_valid_i = 1; id_mret_i = 1; csr_mepc_i = 64'h302; csr_mstatus_i = 64'h80;
      cyc("mret T",   1, 1, 0, 12'h000, 64'h0,    0, 64'h0,   0);
      adv();
      cyc("mret T+1", 1, 0, 1, 12'h300, 64'h1888, 0, 64'h0,   0);
      adv();
      cyc("mret T+2", 1, 0, 0, 12'h000, 64'h0,    1, 64'h300, 0);
      adv();
      clear_inputs();
      cyc("mret T+3", 0, 0, 0, 12'h000, 64'h0,    0, 64'h0,   0);
      adv();

      // irq masked by MIE=0 alongside ebreak
      instr_valid_i = 1; id_ebreak_i = 1; irq_i = 1; pc_i = 64'h40;
      csr_mstatus_i = 64'h0; csr_mtvec_i = 64'h1001;
      run_trap("ebreak", 64'h40, 64'd3, 64'h40, 64'h1800, 64'h1000, 0);
      adv();

      // reset in the middle of a trap sequence
      instr_valid_i = 1; id_ecall_i = 1; pc_i = 64'h500; csr_mtvec_i = 64'h2000; csr_mstatus_i = 64'h0;
      cyc("rst T",   1, 1, 0, 12'h000, 64'h0,   0, 64'h0, 0);
      adv();
      cyc("rst T+1", 1, 0, 1, 12'h341, 64'h500, 0, 64'h0, 0);
      adv();
      cyc("rst T+2", 1, 0, 1, 12'h342, 64'd11,  0, 64'h0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("rst async", 0, 0, 0, 12'h000, 64'h0, 0, 64'h0, 0);
      cyc("rst held", 0, 0, 0, 12'h000, 64'h0, 0, 64'h0, 0);
      #2;
      rst_n = 1'b1;
      clear_inputs();
      adv();
      cyc("rst idle", 0, 0, 0, 12'h000, 64'h0, 0, 64'h0, 0);
      adv();
      instr_valid_i = 1; id_ecall_i = 1; pc_i = 64'h600; csr_mtvec_i = 64'h2000; csr_mstatus_i = 64'h0;
      run_trap("post_rst", 64'h600, 64'd11, 64'h0, 64'h1800, 64'h2000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
